// File: rtl/fetch_decode.sv
// Fetch and decode stages: PC sequencing with redirect/stall handling, the F->D
// pipeline register, and combinational field packing plus immediate generation.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        next_pc_sel,
  input  logic [31:0] jb_target,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic [23:0] D_out,
  output logic [31:0] D_imm,
  output logic        D_valid
);

  localparam int unsigned PC_STEP = 4;

  localparam logic [4:0] OP_IMME   = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  logic [4:0] opcode;

  // Pipeline state; priority is reset, then redirect, then stall, then advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      F_pc    <= RESET_PC;
      D_pc    <= 32'h0000_0000;
      D_inst  <= NOP_INST;
      D_valid <= 1'b0;
    end else if (!next_pc_sel) begin
      // Redirect squashes whatever was fetched this cycle, even under stall.
      F_pc    <= {jb_target[31:2], 2'b00};
      D_pc    <= 32'h0000_0000;
      D_inst  <= NOP_INST;
      D_valid <= 1'b0;
    end else if (!stall) begin
      F_pc    <= F_pc + 32'(PC_STEP);
      D_pc    <= F_pc;
      D_inst  <= im_rdata;
      D_valid <= 1'b1;
    end
  end

  assign opcode = D_inst[6:2];

  // Field bundle for the controller: opcode, rd, funct3, rs1, rs2, funct7[5].
  assign D_out = {D_inst[30], D_inst[24:20], D_inst[19:15],
                  D_inst[14:12], D_inst[11:7], D_inst[6:2]};

  // Immediate generation by instruction format.
  always_comb begin
    D_imm = 32'h0000_0000;
    case (opcode)
      OP_IMME, OP_LOAD, OP_JALR:
        D_imm = {{20{D_inst[31]}}, D_inst[31:20]};
      OP_STORE:
        D_imm = {{20{D_inst[31]}}, D_inst[31:25], D_inst[11:7]};
      OP_BRANCH:
        D_imm = {{19{D_inst[31]}}, D_inst[31], D_inst[7], D_inst[30:25],
                 D_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        D_imm = {D_inst[31:12], 12'h000};
      OP_JAL:
        D_imm = {{11{D_inst[31]}}, D_inst[31], D_inst[19:12], D_inst[20],
                 D_inst[30:21], 1'b0};
      default:
        D_imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: a reference model predicts each cycle's
// outputs into a queue, which is popped and compared after the clock edge.
module tb_fetch_decode;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        next_pc_sel;
  logic [31:0] jb_target;
  logic [31:0] im_rdata;
  logic [31:0] F_pc;
  logic [31:0] D_pc;
  logic [31:0] D_inst;
  logic [23:0] D_out;
  logic [31:0] D_imm;
  logic        D_valid;

  typedef struct {
    logic [31:0] f_pc;
    logic [31:0] d_pc;
    logic [31:0] d_inst;
    logic        d_valid;
    logic [23:0] d_out;
    logic [31:0] d_imm;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic [31:0] m_fpc;
  logic [31:0] m_dpc;
  logic [31:0] m_dinst;
  logic        m_dvalid;

  fetch_decode #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .next_pc_sel(next_pc_sel),
    .jb_target(jb_target),
    .im_rdata(im_rdata),
    .F_pc(F_pc),
    .D_pc(D_pc),
    .D_inst(D_inst),
    .D_out(D_out),
    .D_imm(D_imm),
    .D_valid(D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small instruction memory image.
  function automatic logic [31:0] imem(input logic [31:0] pc);
    case (pc)
      32'h0000_0000: imem = 32'h0050_0093;  // addi x1,x0,5
      32'h0000_0004: imem = 32'hFE20_AE23;  // sw x2,-4(x1)
      32'h0000_0008: imem = 32'hFE00_0CE3;  // beq x0,x0,-8
      32'h0000_000C: imem = 32'h0010_00EF;  // jal x1,2048
      32'h0000_0010: imem = 32'hABCD_E2B7;  // lui x5,0xABCDE
      32'h0000_0100: imem = 32'h00A0_0113;  // addi x2,x0,10
      32'h0000_0104: imem = 32'h4020_8133;  // sub x2,x1,x2
      default:       imem = {pc[23:0], 8'h7F};
    endcase
  endfunction

  function automatic logic [23:0] ref_out(input logic [31:0] i);
    logic [23:0] r;
    r[4:0]   = i[6:2];
    r[9:5]   = i[11:7];
    r[12:10] = i[14:12];
    r[17:13] = i[19:15];
    r[22:18] = i[24:20];
    r[23]    = i[30];
    return r;
  endfunction

  // Immediates via left-justify then arithmetic shift right.
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    logic signed [31:0] t;
    case (i[6:2])
      5'b00100, 5'b00000, 5'b11001: begin t = i; return t >>> 20; end
      5'b01000: begin t = {i[31:25], i[11:7], 20'b0}; return t >>> 20; end
      5'b11000: begin t = {i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}; return t >>> 19; end
      5'b01101, 5'b00101: return i & 32'hFFFF_F000;
      5'b11011: begin t = {i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}; return t >>> 11; end
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict, push; after the edge pop and compare.
  task automatic step(input logic r, input logic s, input logic sel, input logic [31:0] tgt);
    exp_t e;
    logic normal;
    normal      = !r && sel && !s;
    rst         = r;
    stall       = s;
    next_pc_sel = sel;
    jb_target   = tgt;
    im_rdata    = normal ? imem(m_fpc) : 32'hDEAD_BEEF;
    if (r) begin
      m_fpc = RESET_PC; m_dpc = 32'h0; m_dinst = NOP_INST; m_dvalid = 1'b0;
    end else if (!sel) begin
      m_fpc = tgt & 32'hFFFF_FFFC; m_dpc = 32'h0; m_dinst = NOP_INST; m_dvalid = 1'b0;
    end else if (!s) begin
      m_dinst = imem(m_fpc); m_dpc = m_fpc; m_dvalid = 1'b1; m_fpc = m_fpc + 32'd4;
    end
    e.f_pc    = m_fpc;
    e.d_pc    = m_dpc;
    e.d_inst  = m_dinst;
    e.d_valid = m_dvalid;
    e.d_out   = ref_out(m_dinst);
    e.d_imm   = ref_imm(m_dinst);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("F_pc", F_pc, e.f_pc);
    chk("D_pc", D_pc, e.d_pc);
    chk("D_inst", D_inst, e.d_inst);
    chk("D_valid", {31'b0, D_valid}, {31'b0, e.d_valid});
    chk("D_out", {8'b0, D_out}, {8'b0, e.d_out});
    chk("D_imm", D_imm, e.d_imm);
  endtask

  initial begin
    m_fpc = 32'h0; m_dpc = 32'h0; m_dinst = NOP_INST; m_dvalid = 1'b0;
    rst = 1'b1; stall = 1'b0; next_pc_sel = 1'b1; jb_target = 32'h0; im_rdata = 32'h0;

    // Reset, including one edge where a stalled redirect is also requested.
    step(1'b1, 1'b1, 1'b0, 32'h0000_0040);
    step(1'b1, 1'b0, 1'b1, 32'h0);
    chk("rst_D_out", {8'b0, D_out}, 32'h0000_0004);
    chk("rst_D_imm", D_imm, 32'h0);
    chk("rst_F_pc", F_pc, RESET_PC);

    // Sequential fetch.
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("seq_D_pc", D_pc, 32'h0);
    chk("seq_D_inst", D_inst, 32'h0050_0093);
    chk("seq_opc", {27'b0, D_out[4:0]}, 32'h4);
    chk("seq_rd", {27'b0, D_out[9:5]}, 32'h1);
    chk("seq_imm", D_imm, 32'h5);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("sw_imm", D_imm, 32'hFFFF_FFFC);
    chk("pre_stall_F_pc", F_pc, 32'h8);

    // Two stall cycles with junk on im_rdata, then release.
    step(1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    chk("stall_F_pc", F_pc, 32'h8);
    chk("stall_D_pc", D_pc, 32'h4);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("post_stall_F_pc", F_pc, 32'hC);
    chk("beq_imm", D_imm, 32'hFFFF_FFF8);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("jal_imm", D_imm, 32'h0000_0800);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("lui_imm", D_imm, 32'hABCD_E000);

    // Redirect with stall also asserted; target is realigned.
    step(1'b0, 1'b1, 1'b0, 32'h0000_0103);
    chk("redir_F_pc", F_pc, 32'h0000_0100);
    chk("redir_D_inst", D_inst, 32'h0000_0013);
    chk("redir_D_valid", {31'b0, D_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("target_D_inst", D_inst, 32'h00A0_0113);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("rtype_imm", D_imm, 32'h0);

    // PC wrap, then reset during a stall.
    step(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    chk("wrap_start", F_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("wrap_F_pc", F_pc, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0);
    chk("rst_stall_F_pc", F_pc, RESET_PC);
    chk("rst_stall_D_valid", {31'b0, D_valid}, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
